// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N:1 round-robin bus arbiter.
//   MAX_MASTERS : upper bound on requesters; sizes the master index type
//   clog2_min1  : $clog2 that never returns 0 (keeps 1-entry vectors legal)
//   mst_idx_t   : master index, also the ID stored per outstanding transaction
//   bus_req_t   : request half of bus_if bundled for muxing
package bus_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int BE_W        = DATA_W / 8;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = clog2_min1(MAX_MASTERS);

    typedef logic [IDX_W-1:0] mst_idx_t;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_if.sv
// Simple req/gnt bus with a separate response phase (rvalid/err/rdata).
//   master modport : drives req/addr/we/be/wdata, receives gnt/rvalid/err/rdata
//   slave  modport : the opposite direction
interface bus_if;
    import bus_arb_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, err, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/bus_arb_id_fifo.sv
// Circular FIFO holding the master ID of every granted, unanswered transaction.
//   clk_i, rst_ni : clock, synchronous active-low reset (empties the FIFO)
//   push, data_in : enqueue data_in (ignored when full)
//   pop           : dequeue head (ignored when empty)
//   head          : oldest entry
//   full, empty   : derived from the registered count
//   count         : number of stored entries
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int  WIDTH = 3,
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = clog2_min1(DEPTH);

    logic [WIDTH-1:0] mem [2**PTR_W];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/bus_arbnm1s.sv
// Round-robin arbiter: N_MASTERS bus_if requesters onto one bus_if slave.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   master[]      : requester ports (req/addr/we/be/wdata in, gnt/rvalid/err/rdata out)
//   slave         : shared downstream port
// Requests are forwarded combinationally. An ID FIFO remembers who was
// granted so each response is steered back to its issuer in order.
module bus_arbnm1s
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS       = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    bus_if.slave  master [N_MASTERS],
    bus_if.master slave
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    bus_req_t [MAX_MASTERS-1:0] mreq;
    bus_req_t                   fwd;
    logic [N_MASTERS-1:0]       gnt_v, rsp_v;
    mst_idx_t                   ptr_q, lock_idx_q, sel_rr, sel, ptr_nxt, head;
    logic                       lock_q, found, active, slv_req, hs;
    logic                       fifo_full, fifo_empty;
    logic [CNT_W-1:0]           fifo_count;

    // Unused master slots are tied off so the mux can be indexed at full width.
    for (genvar i = 0; i < MAX_MASTERS; i++) begin : g_mst
        if (i < N_MASTERS) begin : g_used
            assign mreq[i] = '{req:   master[i].req,
                               addr:  master[i].addr,
                               we:    master[i].we,
                               be:    master[i].be,
                               wdata: master[i].wdata};
            assign master[i].gnt    = gnt_v[i];
            assign master[i].rvalid = rsp_v[i];
            assign master[i].err    = rsp_v[i] & slave.err;
            assign master[i].rdata  = rsp_v[i] ? slave.rdata : '0;
        end else begin : g_pad
            assign mreq[i] = '0;
        end
    end

    // First requester at or above the pointer, wrapping. Iterating downward
    // lets the closest candidate overwrite farther ones.
    always_comb begin
        sel_rr = ptr_q;
        found  = 1'b0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (mreq[mst_idx_t'((int'(ptr_q) + k) % N_MASTERS)].req) begin
                sel_rr = mst_idx_t'((int'(ptr_q) + k) % N_MASTERS);
                found  = 1'b1;
            end
        end
    end

    // A stalled request pins the selection so its payload cannot change.
    assign sel     = lock_q ? lock_idx_q : sel_rr;
    assign active  = lock_q ? mreq[lock_idx_q].req : found;
    assign fwd     = active ? mreq[sel] : '0;
    assign slv_req = fwd.req & ~fifo_full;
    assign hs      = slv_req & slave.gnt;
    assign ptr_nxt = (sel == mst_idx_t'(N_MASTERS - 1)) ? '0 : sel + 1'b1;

    assign slave.req   = slv_req;
    assign slave.addr  = fwd.addr;
    assign slave.we    = fwd.we;
    assign slave.be    = fwd.be;
    assign slave.wdata = fwd.wdata;

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            gnt_v[i] = hs && (sel == mst_idx_t'(i));
            rsp_v[i] = slave.rvalid && !fifo_empty && (head == mst_idx_t'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (hs) begin
            ptr_q  <= ptr_nxt;
            lock_q <= 1'b0;
        end else if (slv_req) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
        end
    end

    bus_arb_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (hs),
        .pop     (slave.rvalid),
        .data_in (sel),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifndef SYNTHESIS
    // A response with nothing outstanding is a slave protocol error; it is dropped.
    rvalid_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        slave.rvalid |-> (fifo_count != '0))
        else $warning("bus_arbnm1s: rvalid with no outstanding transaction, response dropped");
`endif

endmodule

// File: tb/tb_bus_arbnm1s.sv
module tb_bus_arbnm1s;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]       m_req, m_we, m_gnt, m_rvalid, m_err;
    logic [2:0][31:0] m_addr, m_wdata, m_rdata;
    logic [2:0][3:0]  m_be;
    logic             s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [31:0]      s_addr, s_wdata, s_rdata;
    logic [3:0]       s_be;

    int errs   = 0;
    int checks = 0;

    bus_if mst_if [3] ();
    bus_if slv_if ();

    for (genvar i = 0; i < 3; i++) begin : g_m
        assign mst_if[i].req   = m_req[i];
        assign mst_if[i].addr  = m_addr[i];
        assign mst_if[i].we    = m_we[i];
        assign mst_if[i].be    = m_be[i];
        assign mst_if[i].wdata = m_wdata[i];
        assign m_gnt[i]        = mst_if[i].gnt;
        assign m_rvalid[i]     = mst_if[i].rvalid;
        assign m_err[i]        = mst_if[i].err;
        assign m_rdata[i]      = mst_if[i].rdata;
    end

    assign s_req          = slv_if.req;
    assign s_addr         = slv_if.addr;
    assign s_we           = slv_if.we;
    assign s_be           = slv_if.be;
    assign s_wdata        = slv_if.wdata;
    assign slv_if.gnt     = s_gnt;
    assign slv_if.rvalid  = s_rvalid;
    assign slv_if.err     = s_err;
    assign slv_if.rdata   = s_rdata;

    bus_arbnm1s #(
        .N_MASTERS       (3),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .master (mst_if),
        .slave  (slv_if)
    );

    // Inputs change 1 time unit after posedge; outputs are checked 3 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_err    = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        step();
        step();
        #3;
        checks++; if (s_req !== 1'b0) begin errs++; $display("FAIL rst_sreq: got %b want 0", s_req); end
        checks++; if (m_gnt !== 3'b000) begin errs++; $display("FAIL rst_gnt: got %b want 000", m_gnt); end
        checks++; if (m_rvalid !== 3'b000 || m_err !== 3'b000) begin errs++; $display("FAIL rst_rv_err: got %b/%b want 000/000", m_rvalid, m_err); end
        checks++; if (m_rdata !== '0) begin errs++; $display("FAIL rst_rdata: got %h want 0", m_rdata); end
        checks++; if ({s_addr, s_we, s_be, s_wdata} !== '0) begin errs++; $display("FAIL rst_payload: got %h %b %h %h want 0", s_addr, s_we, s_be, s_wdata); end
        rst_n = 1'b1;
        step();
        #3;
        checks++; if (s_req !== 1'b0 || s_addr !== 32'h0) begin errs++; $display("FAIL post_rst_sreq: got %b %h want 0 0", s_req, s_addr); end
        checks++; if (m_rdata !== '0 || m_rvalid !== 3'b000) begin errs++; $display("FAIL post_rst_rsp: got %h %b want 0 000", m_rdata, m_rvalid); end
        s_err   = 1'b0;
        s_rdata = '0;
        step();
    endtask

    // All three hold req, slave always grants and answers one cycle later.
    task automatic test_round_robin();
        logic [2:0]       rq [5];
        logic [2:0]       eg [5];
        int               rid [5];
        logic [2:0]       erv;
        logic [2:0][31:0] erd;
        rq  = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
        eg  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
        rid = '{-1, 0, 1, 2, 0};
        for (int c = 0; c < 5; c++) begin
            m_req    = rq[c];
            s_gnt    = (c < 4);
            s_rvalid = (rid[c] >= 0);
            s_rdata  = 32'hA0 + 32'(c - 1);
            erv = '0; erd = '0;
            if (rid[c] >= 0) begin erv[rid[c]] = 1'b1; erd[rid[c]] = 32'hA0 + 32'(c - 1); end
            #3;
            checks++; if (m_gnt !== eg[c]) begin errs++; $display("FAIL rr_gnt c%0d: got %b want %b", c, m_gnt, eg[c]); end
            checks++; if (m_rvalid !== erv) begin errs++; $display("FAIL rr_rvalid c%0d: got %b want %b", c, m_rvalid, erv); end
            checks++; if (m_rdata !== erd) begin errs++; $display("FAIL rr_rdata c%0d: got %h want %h", c, m_rdata, erd); end
            if (c < 4) begin
                checks++; if (s_addr !== 32'h100 + 32'(rid[(c+1)%5] * 16) && c < 3) begin errs++; $display("FAIL rr_addr c%0d: got %h", c, s_addr); end
            end
            step();
        end
        s_rvalid = 1'b0;
    endtask

    // Stalled request from master 1 must keep the bus while master 0 arrives.
    task automatic test_lock();
        logic [2:0] rq [4];
        logic       sg [4];
        logic [2:0] eg [4];
        // Grant master 2 first so the pointer sits at 0 (master 0 outranks 1).
        m_req = 3'b100; s_gnt = 1'b1;
        #3;
        checks++; if (m_gnt !== 3'b100) begin errs++; $display("FAIL lk_pre_gnt: got %b want 100", m_gnt); end
        step();
        m_req = 3'b000; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h52;
        #3;
        checks++; if (m_rvalid !== 3'b100 || m_rdata[2] !== 32'h52) begin errs++; $display("FAIL lk_pre_rsp: got %b %h want 100 52", m_rvalid, m_rdata[2]); end
        step();
        s_rvalid = 1'b0;
        rq = '{3'b010, 3'b011, 3'b011, 3'b011};
        sg = '{1'b0, 1'b0, 1'b0, 1'b1};
        eg = '{3'b000, 3'b000, 3'b000, 3'b010};
        for (int c = 0; c < 4; c++) begin
            m_req = rq[c]; s_gnt = sg[c];
            #3;
            checks++; if (s_req !== 1'b1 || s_addr !== 32'h110) begin errs++; $display("FAIL lk_addr c%0d: got %b %h want 1 110", c, s_req, s_addr); end
            checks++; if (m_gnt !== eg[c]) begin errs++; $display("FAIL lk_gnt c%0d: got %b want %b", c, m_gnt, eg[c]); end
            step();
        end
        m_req = 3'b001; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h55;
        #3;
        checks++; if (m_gnt !== 3'b001) begin errs++; $display("FAIL lk_next_gnt: got %b want 001", m_gnt); end
        checks++; if (m_rvalid !== 3'b010 || m_rdata[1] !== 32'h55) begin errs++; $display("FAIL lk_rsp1: got %b %h want 010 55", m_rvalid, m_rdata[1]); end
        step();
        m_req = 3'b000; s_gnt = 1'b0; s_rdata = 32'h66;
        #3;
        checks++; if (m_rvalid !== 3'b001 || m_rdata[0] !== 32'h66) begin errs++; $display("FAIL lk_rsp0: got %b %h want 001 66", m_rvalid, m_rdata[0]); end
        step();
        s_rvalid = 1'b0;
    endtask

    // Two outstanding fill the FIFO; a same-cycle pop must not unblock.
    task automatic test_full();
        logic [2:0]  rq [7];
        logic        sg [7];
        logic        rv [7];
        logic [31:0] rd [7];
        logic [2:0]  eg [7];
        logic        esr [7];
        logic [2:0]  erv [7];
        rq  = '{3'b111, 3'b101, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        sg  = '{1, 1, 1, 1, 1, 0, 0};
        rv  = '{0, 0, 0, 1, 0, 1, 1};
        rd  = '{0, 0, 0, 32'h11, 0, 32'h22, 32'h33};
        eg  = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
        esr = '{1, 1, 0, 0, 1, 0, 0};
        erv = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b100, 3'b001};
        for (int c = 0; c < 7; c++) begin
            m_req = rq[c]; s_gnt = sg[c]; s_rvalid = rv[c]; s_rdata = rd[c];
            #3;
            checks++; if (s_req !== esr[c]) begin errs++; $display("FAIL fl_sreq c%0d: got %b want %b", c, s_req, esr[c]); end
            checks++; if (m_gnt !== eg[c]) begin errs++; $display("FAIL fl_gnt c%0d: got %b want %b", c, m_gnt, eg[c]); end
            checks++; if (m_rvalid !== erv[c]) begin errs++; $display("FAIL fl_rvalid c%0d: got %b want %b", c, m_rvalid, erv[c]); end
            step();
        end
        s_rvalid = 1'b0;
    endtask

    task automatic test_err();
        logic [2:0][31:0] erd;
        m_req = 3'b100; s_gnt = 1'b1;
        #3;
        checks++; if (m_gnt !== 3'b100) begin errs++; $display("FAIL er_gnt: got %b want 100", m_gnt); end
        step();
        m_req = 3'b000; s_gnt = 1'b0; s_rvalid = 1'b1; s_err = 1'b1; s_rdata = 32'hEE;
        erd = '0; erd[2] = 32'hEE;
        #3;
        checks++; if (m_rvalid !== 3'b100 || m_err !== 3'b100) begin errs++; $display("FAIL er_route: got %b/%b want 100/100", m_rvalid, m_err); end
        checks++; if (m_rdata !== erd) begin errs++; $display("FAIL er_rdata: got %h want %h", m_rdata, erd); end
        step();
        s_rvalid = 1'b0; s_err = 1'b0;
    endtask

    task automatic test_reset_outstanding();
        m_req = 3'b011; s_gnt = 1'b1;
        #3;
        checks++; if (m_gnt !== 3'b001) begin errs++; $display("FAIL ro_gnt0: got %b want 001", m_gnt); end
        step();
        m_req = 3'b010;
        #3;
        checks++; if (m_gnt !== 3'b010) begin errs++; $display("FAIL ro_gnt1: got %b want 010", m_gnt); end
        step();
        m_req = 3'b000; s_gnt = 1'b0; rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        s_rvalid = 1'b1; s_rdata = 32'h99;
        #3;
        checks++; if (m_rvalid !== 3'b000 || m_rdata !== '0) begin errs++; $display("FAIL ro_stale: got %b %h want 000 0", m_rvalid, m_rdata); end
        step();
        s_rvalid = 1'b0; m_req = 3'b110; s_gnt = 1'b1;
        #3;
        checks++; if (m_gnt !== 3'b010) begin errs++; $display("FAIL ro_ptr0: got %b want 010", m_gnt); end
        step();
        m_req = 3'b000; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h77;
        #3;
        checks++; if (m_rvalid !== 3'b010 || m_rdata[1] !== 32'h77) begin errs++; $display("FAIL ro_rsp: got %b %h want 010 77", m_rvalid, m_rdata[1]); end
        step();
        s_rvalid = 1'b0;
    endtask

    // Ten transactions from rotating single requesters, random response latency.
    task automatic test_back_to_back();
        int               txn, cyc, mi;
        int               q_id [$];
        logic [31:0]      q_dat [$];
        logic [2:0]       exp_g, exp_rv;
        logic [2:0][31:0] exp_rd;
        txn = 0; cyc = 0;
        while ((txn < 10 || q_id.size() != 0) && cyc < 300) begin
            mi       = txn % 3;
            m_req    = (txn < 10) ? (3'b001 << mi) : 3'b000;
            s_gnt    = 1'b1;
            s_rvalid = (q_id.size() != 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = s_rvalid ? q_dat[0] : 32'h0;
            exp_g    = (txn < 10 && q_id.size() < 2) ? (3'b001 << mi) : 3'b000;
            exp_rv   = '0; exp_rd = '0;
            if (s_rvalid) begin exp_rv[q_id[0]] = 1'b1; exp_rd[q_id[0]] = q_dat[0]; end
            #3;
            checks++; if (m_gnt !== exp_g) begin errs++; $display("FAIL bb_gnt cyc%0d: got %b want %b", cyc, m_gnt, exp_g); end
            checks++; if (m_rvalid !== exp_rv) begin errs++; $display("FAIL bb_rvalid cyc%0d: got %b want %b", cyc, m_rvalid, exp_rv); end
            checks++; if (m_rdata !== exp_rd) begin errs++; $display("FAIL bb_rdata cyc%0d: got %h want %h", cyc, m_rdata, exp_rd); end
            if (s_rvalid) begin void'(q_id.pop_front()); void'(q_dat.pop_front()); end
            if (exp_g != 3'b000) begin
                q_id.push_back(mi);
                q_dat.push_back(32'hB0 + 32'(txn));
                txn++;
            end
            cyc++;
            step();
        end
        checks++; if (cyc >= 300) begin errs++; $display("FAIL bb_timeout: got %0d cycles want < 300", cyc); end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_addr[i]  = 32'h100 + 32'(i * 16);
            m_wdata[i] = 32'hC0 + 32'(i);
            m_be[i]    = 4'hF;
            m_we[i]    = 1'(i % 2);
        end
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_err();
        test_reset_outstanding();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/bus_arbnm1s.md
Name: bus_arbNm1s

Overview:
- Arbitrates N bus masters onto one bus_if slave port with round-robin priority.
- Sits upstream of the 1:N address decoder, e.g. core instruction port, core data port and a DMA engine sharing one interconnect.
- Tracks outstanding granted transactions in an ID FIFO so each rvalid/err/rdata response returns to the master that issued the request.

Parameters:
- N_MASTERS, 2, number of requesting masters; range 2..8.
- MAX_OUTSTANDING, 2, granted-but-unanswered transactions allowed; range 1..8.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  synchronous active-low reset.
- master  bus_if.slave  array[N_MASTERS]  requester ports: req, addr, we, be, wdata in; gnt, rvalid, err, rdata out.
- slave  bus_if.master  1  shared downstream port.

Behaviour:
- Reset is sampled only on posedge clk_i while rst_ni=0. It clears:
  - priority pointer to 0
  - lock flag and locked index
  - ID FIFO to empty
- Output values during and after reset, before any request:
  - slave.req=0
  - all master gnt/rvalid/err=0
  - all master rdata=0
  - slave addr/we/be/wdata=0
- Selection:
  - If lock=1, sel=locked index.
  - Otherwise sel=first master with req=1, searching upward from the pointer and wrapping at N_MASTERS-1.
  - No master requesting: slave.req=0, slave payload=0.
- Forwarding is combinational, with no added request latency:
  - slave.req = master[sel].req & ~fifo_full
  - slave.addr/we/be/wdata = master[sel] payload
- Grant:
  - master[sel].gnt = slave.gnt & slave.req.
  - All other masters get gnt=0.
- Handshake = slave.req & slave.gnt. On a handshake:
  - push sel into the FIFO
  - pointer <= (sel+1) mod N_MASTERS
  - lock <= 0
- Lock:
  - If slave.req=1 and slave.gnt=0, then lock <= 1 and locked index <= sel.
  - This holds selection until the handshake, so a higher-priority arrival cannot change the payload mid-request.
  - Masters keep req asserted until gnt, per bus protocol.
- FIFO full (count=MAX_OUTSTANDING):
  - slave.req=0 and no gnt is given.
  - Lock state is kept.
  - A pop in the same cycle does not unblock that cycle; the decision is registered-count based.
- Response routing:
  - head = FIFO head ID.
  - master[head].rvalid = slave.rvalid; master[head].err = slave.err; master[head].rdata = slave.rdata.
  - All other masters get rvalid=0, err=0, rdata=0.
  - slave.rvalid pops the FIFO.
- Push and pop in the same cycle: count is unchanged, and the pushed ID lands behind the remaining entries.
- Response latency through the arbiter: 0 cycles (combinational).
- slave.rvalid with the FIFO empty (protocol violation):
  - The response is dropped and all master rvalid/err stay 0.
  - The FIFO count stays 0.
  - Flagged by a simulation-only assertion.
- Reset during outstanding transactions:
  - FIFO and lock are cleared and any responses still in flight are lost.
  - The system resets the downstream slaves together with the arbiter.
- With MAX_OUTSTANDING=1, requests are strictly sequential: a new grant can only follow the cycle after the previous rvalid.

Decomposition:
- Package bus_arb_pkg holds:
  - localparam MAX_MASTERS=8
  - function clog2_min1(n), returning max(1,$clog2(n))
  - typedef for master index width
- Sub-module bus_arb_id_fifo:
  - parameters WIDTH, DEPTH
  - ports push/pop/data_in/head/full/empty/count
  - synchronous active-low reset
  - circular buffer with wrap-around read/write pointers

Test Plan:
- N=3, MAX_OUTSTANDING=2; masters 0,1,2 all hold req; slave gnt=1 every cycle and rvalid one cycle later → grants go 0,1,2,0 in consecutive cycles; rvalid returns to 0,1,2,0 one cycle after each grant with matching rdata (0xA0,0xA1,0xA2,0xA3).
- Master 1 requests; slave.gnt=0 for 3 cycles; master 0 raises req in cycle 2 → slave.addr stays master 1's address all 4 cycles; master 1 gets gnt in cycle 4; master 0 is granted next.
- MAX_OUTSTANDING=2; slave grants two requests and withholds rvalid → third request sees slave.req=0 and no gnt; after one rvalid, the grant occurs the following cycle.
- Slave returns err=1 with rvalid for master 2's transaction → only master 2 sees rvalid=1, err=1; the other masters see 0.
- Reset asserted with 2 transactions outstanding, then released → next request from master 1 is granted with pointer at 0; a stale slave.rvalid after reset produces no master rvalid.
- Push and pop in the same cycle with FIFO count=1 → count stays 1, and response order matches grant order over 10 random-latency transactions.
